// File: rtl/sprite_line_scheduler_pkg.sv
// Shared types and helpers for the per-scanline sprite scheduler.
// AlienData field order matches the frame datagram, MSB first.
package sprite_line_scheduler_pkg;

  localparam int SPRITE_MAX_SIDE = 64;
  localparam int ALIEN_W         = 35;

  typedef struct packed {
    logic       _active;
    logic [1:0] _quadrant;
    logic [9:0] _x_pos;
    logic [9:0] _y_pos;
    logic [3:0] _r;
    logic [1:0] _type;
    logic [1:0] _frame;
    logic [1:0] _deriv_left;
    logic [1:0] _deriv_right;
  } AlienData;

  typedef struct packed {
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [3:0] r;
    logic [1:0] alien_type;
    logic [1:0] frame_num;
    logic [1:0] deriv_left;
    logic [1:0] deriv_right;
  } ScheduleSlot;

  // Sprites shrink by two pixels per size step: r = 0..15 gives 64..34.
  function automatic logic [6:0] side_of(input logic [3:0] r);
    return 7'(SPRITE_MAX_SIDE) - {2'b00, r, 1'b0};
  endfunction

endpackage

// File: rtl/sprite_line_scheduler_slot_match.sv
// One display slot: horizontal/vertical range test plus the mirrored
// sprite-ROM address and half-dependent derivative for the current pixel.
module sprite_slot_match
  import sprite_line_scheduler_pkg::*;
(
  input  logic        slot_vld,
  input  logic        valid,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  line,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic [3:0]  r,
  input  logic [1:0]  deriv_left,
  input  logic [1:0]  deriv_right,
  output logic        hit,
  output logic [10:0] addr,
  output logic [1:0]  deriv
);

  logic [6:0] side;
  logic [5:0] half;
  logic [9:0] col_full;
  logic [9:0] row_full;
  logic       left;
  logic [4:0] colm;

  always_comb begin
    side     = side_of(r);
    half     = side[6:1];
    col_full = h_cnt - x_pos;
    row_full = line - y_pos;
    left     = col_full[5:0] < half;
    // Right half mirrors onto the left half so only 32 columns are stored.
    colm     = left ? col_full[4:0] : 5'(side[5:0] - 6'd1 - col_full[5:0]);
    hit      = slot_vld && valid
               && (h_cnt >= x_pos) && (col_full < 10'(side))
               && (line >= y_pos) && (row_full < 10'(side));
    deriv    = left ? deriv_left : deriv_right;
    addr     = {row_full[5:0], colm};
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Latches the frame object list in vblank, builds a sorted per-line slot
// list in hblank, and issues one registered sprite-ROM request per pixel.
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int QUADRANT  = 0,
  parameter int OBJ_LIMIT = 16,
  parameter int SLOTS     = 4,
  parameter int VGA_XRES  = 640,
  parameter int VGA_YRES  = 480,
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 h_cnt,
  input  logic [9:0]                 v_cnt,
  input  logic                       valid,
  input  logic [OBJ_LIMIT*ALIEN_W-1:0] obj_flat,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  output logic                       hit,
  output logic [10:0]                pixel_addr,
  output logic [3:0]                 size_select,
  output logic [1:0]                 deriv_select,
  output logic [1:0]                 alien_type,
  output logic [1:0]                 frame_num,
  output logic                       line_overflow
);

  localparam int IW = (OBJ_LIMIT > 1) ? $clog2(OBJ_LIMIT) : 1;
  localparam int CW = $clog2(SLOTS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;

  AlienData    shadow_q [OBJ_LIMIT];
  AlienData    shadow_d [OBJ_LIMIT];
  ScheduleSlot build_q [SLOTS];
  ScheduleSlot build_d [SLOTS];
  ScheduleSlot disp_q [SLOTS];
  ScheduleSlot disp_d [SLOTS];
  logic [SLOTS-1:0] build_vld_q, build_vld_d, disp_vld_q, disp_vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [9:0]       build_line_q, build_line_d, disp_line_q, disp_line_d;
  scan_state_e      state_q, state_d;
  logic             ovf_q, ovf_d;

  logic        hit_q, hit_d;
  logic [10:0] addr_q, addr_d;
  logic [3:0]  size_q, size_d;
  logic [1:0]  deriv_q, deriv_d, type_q, type_d, frame_q, frame_d;

  logic [9:0]  next_line;
  AlienData    cur;
  logic [6:0]  cur_side;
  logic        qualify;

  logic [SLOTS-1:0] slot_hit;
  logic [10:0]      slot_addr [SLOTS];
  logic [1:0]       slot_deriv [SLOTS];

  assign frame_ready = !rst && (v_cnt == 10'(VGA_YRES)) && (h_cnt == 10'd0);

  always_comb begin
    shadow_d     = shadow_q;
    build_d      = build_q;
    build_vld_d  = build_vld_q;
    disp_d       = disp_q;
    disp_vld_d   = disp_vld_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    build_line_d = build_line_q;
    disp_line_d  = disp_line_q;
    state_d      = state_q;
    ovf_d        = ovf_q;

    next_line = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
    cur       = shadow_q[idx_q];
    cur_side  = side_of(cur._r);
    qualify   = cur._active && (cur._quadrant == 2'(QUADRANT))
                && ({1'b0, cur._y_pos} <= {1'b0, build_line_q})
                && ({1'b0, build_line_q} < {1'b0, cur._y_pos} + 11'(cur_side));

    if (frame_ready && frame_valid) begin
      for (int k = 0; k < OBJ_LIMIT; k++) begin
        shadow_d[k] = AlienData'(obj_flat[ALIEN_W*k +: ALIEN_W]);
      end
      ovf_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (h_cnt == 10'(VGA_XRES)) begin
          build_line_d = next_line;
          build_vld_d  = '0;
          cnt_d        = '0;
          idx_d        = '0;
          // Lines in vblank get an empty bank without scanning.
          state_d      = (next_line >= 10'(VGA_YRES)) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (qualify) begin
          if (cnt_q == CW'(SLOTS)) begin
            ovf_d = 1'b1;
          end else begin
            for (int s = 0; s < SLOTS; s++) begin
              if (cnt_q == CW'(s)) begin
                build_d[s].x_pos       = cur._x_pos;
                build_d[s].y_pos       = cur._y_pos;
                build_d[s].r           = cur._r;
                build_d[s].alien_type  = cur._type;
                build_d[s].frame_num   = cur._frame;
                build_d[s].deriv_left  = cur._deriv_left;
                build_d[s].deriv_right = cur._deriv_right;
                build_vld_d[s]         = 1'b1;
              end
            end
            cnt_d = cnt_q + CW'(1);
          end
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(OBJ_LIMIT - 1)) state_d = DONE;
      end
      default: ;
    endcase

    if (h_cnt == 10'(H_TOTAL - 1)) begin
      disp_d      = build_q;
      disp_vld_d  = build_vld_q;
      disp_line_d = build_line_q;
      build_vld_d = '0;
      cnt_d       = '0;
      state_d     = IDLE;
    end
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    sprite_slot_match u_match (
      .slot_vld    (disp_vld_q[gi]),
      .valid       (valid),
      .h_cnt       (h_cnt),
      .line        (disp_line_q),
      .x_pos       (disp_q[gi].x_pos),
      .y_pos       (disp_q[gi].y_pos),
      .r           (disp_q[gi].r),
      .deriv_left  (disp_q[gi].deriv_left),
      .deriv_right (disp_q[gi].deriv_right),
      .hit         (slot_hit[gi]),
      .addr        (slot_addr[gi]),
      .deriv       (slot_deriv[gi])
    );
  end

  // Walk downwards so the lowest (nearest) slot is the last one written.
  always_comb begin
    hit_d   = 1'b0;
    addr_d  = '0;
    size_d  = '0;
    deriv_d = '0;
    type_d  = '0;
    frame_d = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (slot_hit[s]) begin
        hit_d   = 1'b1;
        addr_d  = slot_addr[s];
        size_d  = disp_q[s].r;
        deriv_d = slot_deriv[s];
        type_d  = disp_q[s].alien_type;
        frame_d = disp_q[s].frame_num;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '{default: '0};
      build_q      <= '{default: '0};
      disp_q       <= '{default: '0};
      build_vld_q  <= '0;
      disp_vld_q   <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      build_line_q <= '0;
      disp_line_q  <= '0;
      state_q      <= IDLE;
      ovf_q        <= 1'b0;
      hit_q        <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      deriv_q      <= '0;
      type_q       <= '0;
      frame_q      <= '0;
    end else begin
      shadow_q     <= shadow_d;
      build_q      <= build_d;
      disp_q       <= disp_d;
      build_vld_q  <= build_vld_d;
      disp_vld_q   <= disp_vld_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      build_line_q <= build_line_d;
      disp_line_q  <= disp_line_d;
      state_q      <= state_d;
      ovf_q        <= ovf_d;
      hit_q        <= hit_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      deriv_q      <= deriv_d;
      type_q       <= type_d;
      frame_q      <= frame_d;
    end
  end

  assign hit           = hit_q;
  assign pixel_addr    = addr_q;
  assign size_select   = size_q;
  assign deriv_select  = deriv_q;
  assign alien_type    = type_q;
  assign frame_num     = frame_q;
  assign line_overflow = ovf_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed scenarios for sprite_line_scheduler with hand-computed pixel
// requests; counters are jumped to the lines of interest to keep runs short.
module tb_sprite_line_scheduler;
  import sprite_line_scheduler_pkg::*;

  localparam int Q   = 1;
  localparam int OBJ = 16;
  localparam int SL  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        h_cnt, v_cnt;
  logic              valid;
  logic [OBJ*35-1:0] obj_flat;
  logic              frame_valid;
  logic              frame_ready;
  logic              hit;
  logic [10:0]       pixel_addr;
  logic [3:0]        size_select;
  logic [1:0]        deriv_select, alien_type, frame_num;
  logic              line_overflow;

  AlienData objs [OBJ];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          hb;
    int          v;
    int          h;
    logic [21:0] exp;
  } vec_t;

  sprite_line_scheduler #(
    .QUADRANT(Q), .OBJ_LIMIT(OBJ), .SLOTS(SL),
    .VGA_XRES(640), .VGA_YRES(480), .H_TOTAL(800), .V_TOTAL(525)
  ) dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .obj_flat(obj_flat), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .hit(hit), .pixel_addr(pixel_addr), .size_select(size_select),
    .deriv_select(deriv_select), .alien_type(alien_type), .frame_num(frame_num),
    .line_overflow(line_overflow)
  );

  always #5 clk = ~clk;

  function automatic AlienData mk(input logic [1:0] q, input int x, input int y,
                                  input int r, input int t, input int f,
                                  input int dl, input int dr);
    AlienData a;
    a              = '0;
    a._active      = 1'b1;
    a._quadrant    = q;
    a._x_pos       = 10'(x);
    a._y_pos       = 10'(y);
    a._r           = 4'(r);
    a._type        = 2'(t);
    a._frame       = 2'(f);
    a._deriv_left  = 2'(dl);
    a._deriv_right = 2'(dr);
    return a;
  endfunction

  function automatic logic [21:0] px(input logic h, input int a, input int s,
                                     input int d, input int t, input int f);
    return {h, 11'(a), 4'(s), 2'(d), 2'(t), 2'(f)};
  endfunction

  function automatic logic [21:0] outs();
    return {hit, pixel_addr, size_select, deriv_select, alien_type, frame_num};
  endfunction

  task automatic set_cnt(input int v, input int h);
    v_cnt = 10'(v);
    h_cnt = 10'(h);
    valid = (h < 640) && (v < 480);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_objs();
    for (int k = 0; k < OBJ; k++) obj_flat[35*k +: 35] = objs[k];
  endtask

  task automatic clear_objs();
    for (int k = 0; k < OBJ; k++) objs[k] = '0;
    pack_objs();
  endtask

  task automatic hblank(input int v);
    for (int h = 640; h < 800; h++) begin
      set_cnt(v, h);
      tick();
    end
  endtask

  task automatic latch(input logic fv);
    pack_objs();
    frame_valid = fv;
    set_cnt(480, 0);
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic pix(input int v, input int h);
    set_cnt(v, h);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frame_valid = 1'b0;
    clear_objs();
    set_cnt(0, 0);
    repeat (3) tick();
    n_cmp++;
    $display("txn reset_outputs got=%h line_overflow=%0d frame_ready=%0d", outs(), line_overflow, frame_ready);
    if ({outs(), line_overflow, frame_ready} !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 000000", {outs(), line_overflow, frame_ready});
    end
    set_cnt(480, 0);
    #1;
    n_cmp++;
    $display("txn reset_frame_ready v=480 h=0 frame_ready=%0d", frame_ready);
    if (frame_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_frame_ready: got %0d want 0", frame_ready);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    vec_t tv[$];
    clear_objs();
    objs[0] = mk(2'(Q), 100, 50, 0, 2, 1, 1, 2);
    latch(1'b1);
    tv.push_back('{49,  50,  99, px(0, 0, 0, 0, 0, 0)});
    tv.push_back('{-1,  50, 100, px(1, 0, 0, 1, 2, 1)});
    tv.push_back('{-1,  50, 131, px(1, 31, 0, 1, 2, 1)});
    tv.push_back('{-1,  50, 132, px(1, 31, 0, 2, 2, 1)});
    tv.push_back('{-1,  50, 163, px(1, 0, 0, 2, 2, 1)});
    tv.push_back('{-1,  50, 164, px(0, 0, 0, 0, 0, 0)});
    tv.push_back('{52,  53, 101, px(1, 97, 0, 1, 2, 1)});
    tv.push_back('{112, 113, 100, px(1, 2016, 0, 1, 2, 1)});
    tv.push_back('{113, 114, 100, px(0, 0, 0, 0, 0, 0)});
    foreach (tv[i]) begin
      if (tv[i].hb >= 0) hblank(tv[i].hb);
      pix(tv[i].v, tv[i].h);
      n_cmp++;
      $display("txn single[%0d] v=%0d h=%0d got=%h exp=%h", i, tv[i].v, tv[i].h, outs(), tv[i].exp);
      if (outs() !== tv[i].exp) begin
        n_bad++;
        $display("FAIL single[%0d]: got %h want %h", i, outs(), tv[i].exp);
      end
    end
  endtask

  task automatic test_overlap();
    vec_t tv[$];
    clear_objs();
    objs[0] = mk(2'(Q), 200, 300, 3, 1, 2, 0, 3);
    objs[1] = mk(2'(Q), 210, 300, 1, 3, 3, 2, 1);
    latch(1'b1);
    tv.push_back('{299, 300, 220, px(1, 20, 3, 0, 1, 2)});
    tv.push_back('{-1,  300, 205, px(1, 5, 3, 0, 1, 2)});
    tv.push_back('{-1,  300, 257, px(1, 0, 3, 3, 1, 2)});
    tv.push_back('{-1,  300, 258, px(1, 13, 1, 1, 3, 3)});
    tv.push_back('{-1,  300, 265, px(1, 6, 1, 1, 3, 3)});
    tv.push_back('{300, 301, 200, px(1, 32, 3, 0, 1, 2)});
    foreach (tv[i]) begin
      if (tv[i].hb >= 0) hblank(tv[i].hb);
      pix(tv[i].v, tv[i].h);
      n_cmp++;
      $display("txn overlap[%0d] v=%0d h=%0d got=%h exp=%h", i, tv[i].v, tv[i].h, outs(), tv[i].exp);
      if (outs() !== tv[i].exp) begin
        n_bad++;
        $display("FAIL overlap[%0d]: got %h want %h", i, outs(), tv[i].exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [21:0] exp;
    clear_objs();
    for (int k = 0; k < 4; k++) objs[k] = mk(2'(Q), 50 + 70*k, 200, 0, 0, 0, 3, 3);
    latch(1'b1);
    hblank(199);
    n_cmp++;
    $display("txn overflow_exact_slots line_overflow=%0d", line_overflow);
    if (line_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_exact_slots: got %0d want 0", line_overflow);
    end
    pix(200, 265);
    exp = px(1, 5, 0, 3, 0, 0);
    n_cmp++;
    $display("txn overflow_slot3 v=200 h=265 got=%h exp=%h", outs(), exp);
    if (outs() !== exp) begin
      n_bad++;
      $display("FAIL overflow_slot3: got %h want %h", outs(), exp);
    end

    objs[4] = mk(2'(Q), 330, 200, 0, 0, 0, 3, 3);
    latch(1'b1);
    hblank(199);
    n_cmp++;
    $display("txn overflow_set line_overflow=%0d", line_overflow);
    if (line_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_set: got %0d want 1", line_overflow);
    end
    pix(200, 335);
    n_cmp++;
    $display("txn overflow_dropped v=200 h=335 got=%h", outs());
    if (outs() !== 22'h0) begin
      n_bad++;
      $display("FAIL overflow_dropped: got %h want 000000", outs());
    end
    pix(200, 55);
    exp = px(1, 5, 0, 3, 0, 0);
    n_cmp++;
    $display("txn overflow_slot0 v=200 h=55 got=%h exp=%h", outs(), exp);
    if (outs() !== exp) begin
      n_bad++;
      $display("FAIL overflow_slot0: got %h want %h", outs(), exp);
    end
    latch(1'b0);
    n_cmp++;
    $display("txn overflow_hold_no_valid line_overflow=%0d", line_overflow);
    if (line_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_hold_no_valid: got %0d want 1", line_overflow);
    end
    latch(1'b1);
    n_cmp++;
    $display("txn overflow_clear line_overflow=%0d", line_overflow);
    if (line_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_clear: got %0d want 0", line_overflow);
    end
  endtask

  task automatic test_handshake();
    int pulses;
    int pts_v[8];
    int pts_h[8];
    logic fr_at_latch;
    clear_objs();
    objs[0] = mk(2'(Q), 100, 20, 0, 1, 1, 1, 1);
    latch(1'b1);
    objs[0] = mk(2'(Q), 400, 20, 0, 2, 2, 2, 2);
    pack_objs();
    frame_valid = 1'b1;
    hblank(19);
    pix(20, 100);
    n_cmp++;
    $display("txn handshake_old_list v=20 h=100 hit=%0d", hit);
    if (hit !== 1'b1) begin
      n_bad++;
      $display("FAIL handshake_old_list: got hit %0d want 1", hit);
    end
    pix(20, 400);
    n_cmp++;
    $display("txn handshake_new_not_yet v=20 h=400 hit=%0d", hit);
    if (hit !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake_new_not_yet: got hit %0d want 0", hit);
    end
    pts_v = '{10, 100, 479, 479, 480, 480, 480, 481};
    pts_h = '{0, 0, 0, 799, 0, 1, 799, 0};
    pulses = 0;
    fr_at_latch = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_cnt(pts_v[i], pts_h[i]);
      #1;
      if (frame_ready === 1'b1) pulses++;
      if (pts_v[i] == 480 && pts_h[i] == 0) fr_at_latch = frame_ready;
      tick();
    end
    frame_valid = 1'b0;
    n_cmp++;
    $display("txn handshake_pulses count=%0d", pulses);
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL handshake_pulses: got %0d pulses want 1", pulses);
    end
    n_cmp++;
    $display("txn handshake_ready_at_480_0 frame_ready=%0d", fr_at_latch);
    if (fr_at_latch !== 1'b1) begin
      n_bad++;
      $display("FAIL handshake_ready_at_480_0: got %0d want 1", fr_at_latch);
    end
    hblank(19);
    pix(20, 400);
    n_cmp++;
    $display("txn handshake_new_list v=20 h=400 got=%h", outs());
    if (outs() !== px(1, 0, 0, 2, 2, 2)) begin
      n_bad++;
      $display("FAIL handshake_new_list: got %h want %h", outs(), px(1, 0, 0, 2, 2, 2));
    end
    pix(20, 100);
    n_cmp++;
    $display("txn handshake_old_gone v=20 h=100 hit=%0d", hit);
    if (hit !== 1'b0) begin
      n_bad++;
      $display("FAIL handshake_old_gone: got hit %0d want 0", hit);
    end
  endtask

  task automatic test_quadrant_wrap();
    vec_t tv[$];
    clear_objs();
    objs[0] = mk(2'(Q ^ 1), 100, 0, 0, 1, 1, 1, 1);
    objs[1] = mk(2'(Q), 300, 0, 0, 2, 3, 1, 0);
    objs[2] = mk(2'(Q), 500, 0, 0, 1, 1, 1, 1);
    objs[2]._active = 1'b0;
    latch(1'b1);
    tv.push_back('{524, 0, 100, px(0, 0, 0, 0, 0, 0)});
    tv.push_back('{-1,  0, 300, px(1, 0, 0, 1, 2, 3)});
    tv.push_back('{-1,  0, 301, px(1, 1, 0, 1, 2, 3)});
    tv.push_back('{-1,  0, 500, px(0, 0, 0, 0, 0, 0)});
    foreach (tv[i]) begin
      if (tv[i].hb >= 0) hblank(tv[i].hb);
      pix(tv[i].v, tv[i].h);
      n_cmp++;
      $display("txn quad_wrap[%0d] v=%0d h=%0d got=%h exp=%h", i, tv[i].v, tv[i].h, outs(), tv[i].exp);
      if (outs() !== tv[i].exp) begin
        n_bad++;
        $display("FAIL quad_wrap[%0d]: got %h want %h", i, outs(), tv[i].exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_objs();
    for (int k = 0; k < 5; k++) objs[k] = mk(2'(Q), 300 + 80*k, 90, 0, 1, 1, 1, 1);
    latch(1'b1);
    hblank(99);
    pix(100, 300);
    n_cmp++;
    $display("txn reset_mid_before got=%h line_overflow=%0d", outs(), line_overflow);
    if ({outs(), line_overflow} !== {px(1, 320, 0, 1, 1, 1), 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_before: got %h/%0d want %h/1", outs(), line_overflow, px(1, 320, 0, 1, 1, 1));
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_cnt(100, 300 + i);
      tick();
      n_cmp++;
      $display("txn reset_mid_hold[%0d] hit=%0d ovf=%0d fr=%0d", i, hit, line_overflow, frame_ready);
      if ({hit, line_overflow, frame_ready} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_mid_hold[%0d]: got %b want 000", i, {hit, line_overflow, frame_ready});
      end
    end
    rst = 1'b0;
    pix(100, 305);
    n_cmp++;
    $display("txn reset_mid_line100 hit=%0d", hit);
    if (hit !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_line100: got hit %0d want 0", hit);
    end
    for (int v = 101; v <= 102; v++) begin
      hblank(v - 1);
      pix(v, 300);
      n_cmp++;
      $display("txn reset_mid_line%0d hit=%0d ovf=%0d", v, hit, line_overflow);
      if ({hit, line_overflow} !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_mid_line%0d: got %b want 00", v, {hit, line_overflow});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_overflow();
    test_handshake();
    test_quadrant_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
